// File: rtl/sram_array_ctrl_64x25.sv
// Purpose : controller for the R0/W0 ports of a 64x25 1R1W SRAM macro; zero-sweeps
//           the array after reset, then serves client reads/writes over valid/ready.
// Latency : write lands in the macro on the accept edge; read data is returned 1 cycle after accept.
// Backpr. : a 1-entry skid holds a stalled response; reads stall while it is full or a response is pending.
//
// Ports:
//   i_clock, i_reset_n         clock, asynchronous active-low reset
//   o_init_done                1 once the zero sweep has finished
//   i_rreq_* / o_rreq_ready    read request (address) channel
//   o_rresp_* / i_rresp_ready  read response channel
//   i_wreq_* / o_wreq_ready    write request (address + data) channel
//   o_sram_* / i_sram_rdata    macro R0/W0 port signals
module sram_array_ctrl_64x25 #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 25,
    parameter int ADDR_W = 6
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    output logic              o_init_done,
    input  logic              i_rreq_valid,
    output logic              o_rreq_ready,
    input  logic [ADDR_W-1:0] i_rreq_addr,
    output logic              o_rresp_valid,
    input  logic              i_rresp_ready,
    output logic [WIDTH-1:0]  o_rresp_data,
    input  logic              i_wreq_valid,
    output logic              o_wreq_ready,
    input  logic [ADDR_W-1:0] i_wreq_addr,
    input  logic [WIDTH-1:0]  i_wreq_data,
    output logic              o_sram_ren,
    output logic [ADDR_W-1:0] o_sram_raddr,
    input  logic [WIDTH-1:0]  i_sram_rdata,
    output logic              o_sram_wen,
    output logic [ADDR_W-1:0] o_sram_waddr,
    output logic [WIDTH-1:0]  o_sram_wdata,
    output logic              o_sram_wmask
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic              r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic              r_inflight;
    logic              r_skid_valid;
    logic [WIDTH-1:0]  r_skid_data;
    logic [ADDR_W-1:0] r_raddr_hold;
    logic [ADDR_W-1:0] r_waddr_hold;

    logic w_run;
    logic w_init_wr;
    logic w_collide;
    logic w_wr_fire;
    logic w_rd_fire;

    assign w_run = (r_state == ST_RUN);

    // The state register resets to INIT asynchronously, so the sweep strobe is the
    // only combinational output that must be masked by reset to read 0 at once.
    assign w_init_wr = i_reset_n && (r_state == ST_INIT);

    // Same-address write and read in one cycle: let the write go first and hold
    // the read for a cycle so it observes the freshly written data.
    assign w_collide = i_wreq_valid && i_rreq_valid && (i_wreq_addr == i_rreq_addr);

    assign o_wreq_ready = w_run;
    assign w_wr_fire    = i_wreq_valid && w_run;

    // A pending response that the client is not taking this cycle would need the
    // skid next cycle, so no new read may be launched behind it.
    assign o_rreq_ready = w_run && !r_skid_valid && !(r_inflight && !i_rresp_ready) && !w_collide;
    assign w_rd_fire    = i_rreq_valid && o_rreq_ready;

    assign o_sram_wen   = w_init_wr || w_wr_fire;
    assign o_sram_wmask = o_sram_wen;
    assign o_sram_waddr = w_init_wr ? r_cnt : (w_wr_fire ? i_wreq_addr : r_waddr_hold);
    assign o_sram_wdata = w_wr_fire ? i_wreq_data : '0;

    assign o_sram_ren   = w_rd_fire;
    assign o_sram_raddr = w_rd_fire ? i_rreq_addr : r_raddr_hold;

    // The skid and the in-flight slot are never both occupied, so the skid has priority.
    assign o_rresp_valid = r_inflight || r_skid_valid;
    assign o_rresp_data  = r_skid_valid ? r_skid_data : (r_inflight ? i_sram_rdata : '0);
    assign o_init_done   = r_init_done;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_init_done  <= 1'b0;
            r_inflight   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_raddr_hold <= '0;
            r_waddr_hold <= '0;
        end else begin
            r_raddr_hold <= o_sram_raddr;
            r_waddr_hold <= o_sram_waddr;
            r_inflight   <= w_rd_fire;

            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + ADDR_W'(1);
                if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                end
            end

            if (r_skid_valid) begin
                if (i_rresp_ready) begin
                    r_skid_valid <= 1'b0;
                end
            end else if (r_inflight && !i_rresp_ready) begin
                // Capture now: the macro output is only valid this one cycle.
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_array_ctrl_64x25.sv
module tb_sram_array_ctrl_64x25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        rreq_valid, rreq_ready;
    logic [5:0]  rreq_addr;
    logic        rresp_valid, rresp_ready;
    logic [24:0] rresp_data;
    logic        wreq_valid, wreq_ready;
    logic [5:0]  wreq_addr;
    logic [24:0] wreq_data;
    logic        sram_ren;
    logic [5:0]  sram_raddr;
    logic [24:0] sram_rdata;
    logic        sram_wen;
    logic [5:0]  sram_waddr;
    logic [24:0] sram_wdata;
    logic        sram_wmask;

    int passed = 0;
    int total  = 0;
    int rsp_cnt = 0;

    logic [24:0] mem [64];      // behavioural macro
    logic [24:0] ref_mem [64];  // expected array contents
    logic [24:0] sb [$];        // expected read responses, in order

    always #5 clk = ~clk;

    sram_array_ctrl_64x25 dut (
        .i_clock(clk), .i_reset_n(rst_n), .o_init_done(init_done),
        .i_rreq_valid(rreq_valid), .o_rreq_ready(rreq_ready), .i_rreq_addr(rreq_addr),
        .o_rresp_valid(rresp_valid), .i_rresp_ready(rresp_ready), .o_rresp_data(rresp_data),
        .i_wreq_valid(wreq_valid), .o_wreq_ready(wreq_ready), .i_wreq_addr(wreq_addr),
        .i_wreq_data(wreq_data),
        .o_sram_ren(sram_ren), .o_sram_raddr(sram_raddr), .i_sram_rdata(sram_rdata),
        .o_sram_wen(sram_wen), .o_sram_waddr(sram_waddr), .o_sram_wdata(sram_wdata),
        .o_sram_wmask(sram_wmask)
    );

    // Macro model: 1-cycle registered read, masked write, read returns old data.
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= mem[sram_raddr];
        if (sram_wen && sram_wmask) mem[sram_waddr] <= sram_wdata;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard: pop on a completed response, then push on an accepted read,
    // then apply an accepted write to the reference array.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (rresp_valid && rresp_ready) begin
                rsp_cnt++;
                if (sb.size() == 0) chk("rsp_unexpected", 96'(rresp_valid), 96'd0);
                else chk("rsp_data", 96'(rresp_data), 96'(sb.pop_front()));
            end
            if (rreq_valid && rreq_ready) sb.push_back(ref_mem[rreq_addr]);
            if (wreq_valid && wreq_ready) ref_mem[wreq_addr] = wreq_data;
        end
    end

    function automatic logic [95:0] all_outs();
        return 96'({init_done, rreq_ready, rresp_valid, rresp_data, wreq_ready, sram_ren,
                    sram_raddr, sram_wen, sram_waddr, sram_wdata, sram_wmask});
    endfunction

    task automatic drive_idle();
        rreq_valid = 0; rreq_addr = 0; rresp_ready = 1;
        wreq_valid = 0; wreq_addr = 0; wreq_data = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Call right after reset release (#1 after an edge): checks cycles 0..63 and 64.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk({tag, "_sweep"},
                96'({sram_wen, sram_wmask, sram_waddr, sram_wdata, rreq_ready, wreq_ready, init_done, sram_ren, rresp_valid}),
                96'({1'b1, 1'b1, 6'(i), 25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        end
        @(negedge clk);
        chk({tag, "_done"}, 96'({init_done, sram_wen, wreq_ready}), 96'({1'b1, 1'b0, 1'b1}));
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 25'h1555555;
            ref_mem[i] = 25'd0;
        end
        sram_rdata = 25'h0;
        drive_idle();
        rst_n = 0;
        #1;
        chk("reset_outs", all_outs(), 96'd0);

        // 1. sweep after release
        @(posedge clk); #1 rst_n = 1;
        sweep_check("t1");

        // 2. write 5 then read 5
        next_cycle();
        wreq_valid = 1; wreq_addr = 5; wreq_data = 25'h1ABCDEF;
        @(negedge clk);
        chk("t2_wr", 96'({wreq_ready, sram_wen, sram_waddr, sram_wdata}), 96'({1'b1, 1'b1, 6'd5, 25'h1ABCDEF}));
        next_cycle();
        wreq_valid = 0; rreq_valid = 1; rreq_addr = 5;
        @(negedge clk);
        chk("t2_rd_acc", 96'({rreq_ready, sram_ren, sram_raddr, rresp_valid}), 96'({1'b1, 1'b1, 6'd5, 1'b0}));
        next_cycle();
        rreq_valid = 0;
        @(negedge clk);
        chk("t2_rsp", 96'({rresp_valid, rresp_data}), 96'({1'b1, 25'h1ABCDEF}));
        next_cycle();
        @(negedge clk);
        chk("t2_rsp_gone", 96'(rresp_valid), 96'd0);

        // prepare distinct contents for 1,2,3,7
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            wreq_valid = 1;
            wreq_addr  = (i == 3) ? 6'd7 : 6'(i + 1);
            wreq_data  = (i == 3) ? 25'h0000011 : 25'(32'h111 * (i + 1));
        end
        next_cycle();
        wreq_valid = 0;

        // 3. back-to-back reads 1,2,3
        n0 = rsp_cnt;
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            rreq_valid = 1; rreq_addr = 6'(i);
            @(negedge clk);
            chk("t3_acc", 96'(rreq_ready), 96'd1);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            rreq_valid = 0;
            @(negedge clk);
            chk("t3_tail_valid", 96'(rresp_valid), (i == 0) ? 96'd1 : 96'd0);
        end
        chk("t3_count", 96'(rsp_cnt - n0), 96'd3);

        // 4. stalled read of 7, overwritten meanwhile
        n0 = rsp_cnt;
        next_cycle();
        rreq_valid = 1; rreq_addr = 7; rresp_ready = 0;
        @(negedge clk);
        chk("t4_acc", 96'(rreq_ready), 96'd1);
        next_cycle();
        rreq_valid = 0; wreq_valid = 1; wreq_addr = 7; wreq_data = 25'h1FFFFFF;
        @(negedge clk);
        chk("t4_pend", 96'({rresp_valid, rresp_data, rreq_ready}), 96'({1'b1, 25'h0000011, 1'b0}));
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            wreq_valid = 0;
            @(negedge clk);
            chk("t4_held", 96'({rresp_valid, rresp_data, rreq_ready}), 96'({1'b1, 25'h0000011, 1'b0}));
        end
        next_cycle();
        rresp_ready = 1;
        @(negedge clk);
        chk("t4_release", 96'({rresp_valid, rresp_data}), 96'({1'b1, 25'h0000011}));
        next_cycle();
        @(negedge clk);
        chk("t4_one_rsp", 96'({rresp_valid, 8'(rsp_cnt - n0)}), 96'({1'b0, 8'd1}));

        // 5. same-cycle write/read of 9
        next_cycle();
        wreq_valid = 1; wreq_addr = 9; wreq_data = 25'h0AAAAAA;
        rreq_valid = 1; rreq_addr = 9;
        @(negedge clk);
        chk("t5_collide", 96'({wreq_ready, sram_wen, rreq_ready, sram_ren}), 96'({1'b1, 1'b1, 1'b0, 1'b0}));
        next_cycle();
        wreq_valid = 0;
        @(negedge clk);
        chk("t5_retry", 96'(rreq_ready), 96'd1);
        next_cycle();
        rreq_valid = 0;
        @(negedge clk);
        chk("t5_rsp", 96'({rresp_valid, rresp_data}), 96'({1'b1, 25'h0AAAAAA}));
        next_cycle();

        // 6a. reset mid-sweep at cnt=20
        rst_n = 0;
        #1 chk("t6_rst_outs", all_outs(), 96'd0);
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 21; i++) @(negedge clk);
        chk("t6_at20", 96'({sram_wen, sram_waddr}), 96'({1'b1, 6'd20}));
        rst_n = 0;
        #1 chk("t6_mid_sweep_outs", all_outs(), 96'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        sweep_check("t6a");

        // 6b. reset with a response held in the skid
        next_cycle();
        rreq_valid = 1; rreq_addr = 5; rresp_ready = 0;
        next_cycle();
        rreq_valid = 0;
        next_cycle();
        @(negedge clk);
        chk("t6_skid_full", 96'({rresp_valid, rreq_ready}), 96'({1'b1, 1'b0}));
        rst_n = 0;
        #1 chk("t6_skid_rst_outs", all_outs(), 96'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        rresp_ready = 1;
        sweep_check("t6b");
        next_cycle();
        @(negedge clk);
        chk("t6_no_stale", 96'({rresp_valid, 8'(sb.size())}), 96'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
